vr_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream valid/ready channel (the checker side of `top`) between `NUM_REQ` upstream generators. Each accepted word passes through a single output register tagged with its source index. An optional burst lock keeps the grant on one requester for up to `BURST_LEN` consecutive words. The block sits between the generator instances and the checker, so multi-source traffic can be exercised with the existing bench flow.

---
 rtl/vr_rr_arbiter_if.sv | 27 ++
 rtl/vr_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_vr_rr_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vr_rr_arbiter_if.sv
// Channel bundle for vr_rr_arbiter: NUM_REQ upstream valid/ready sources and
// one registered downstream valid/ready port tagged with the source index.
interface vr_rr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            up_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] up_data;
    logic [NUM_REQ-1:0]            up_ready;
    logic                          down_valid;
    logic [DATA_WIDTH-1:0]         down_data;
    logic [SRC_W-1:0]              down_src;
    logic                          down_ready;

    // master: generators plus checker; slave: the arbiter itself
    modport master (
        output up_valid, up_data, down_ready,
        input  up_ready, down_valid, down_data, down_src
    );

    modport slave (
        input  up_valid, up_data, down_ready,
        output up_ready, down_valid, down_data, down_src
    );
endinterface

// File: rtl/vr_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output between
// NUM_REQ sources, with an optional lock of up to BURST_LEN words per owner.
module vr_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    vr_rr_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    logic                  down_valid_q, down_valid_d;
    logic [DATA_WIDTH-1:0] down_data_q, down_data_d;
    logic [SRC_W-1:0]      down_src_q, down_src_d;
    logic [SRC_W-1:0]      ptr_q, ptr_d;
    logic                  lock_q, lock_d;
    logic [SRC_W-1:0]      own_q, own_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  can_take;
    logic                  owner_hold;
    logic [SRC_W-1:0]      search_start;
    logic                  gnt_found;
    logic [SRC_W-1:0]      gnt_idx;
    logic                  accept;

    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return SRC_W'(sum);
    endfunction

    assign can_take = !down_valid_q || bus.down_ready;

    // A locked owner that drops valid hands the search to its neighbour at once
    always_comb begin
        owner_hold   = lock_q && bus.up_valid[own_q];
        search_start = lock_q ? wrap_add(own_q, 1) : ptr_q;
        gnt_found    = 1'b0;
        gnt_idx      = '0;
        if (owner_hold) begin
            gnt_found = 1'b1;
            gnt_idx   = own_q;
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!gnt_found && bus.up_valid[wrap_add(search_start, j)]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = wrap_add(search_start, j);
                end
            end
        end
    end

    assign accept = gnt_found && can_take;

    always_comb begin
        bus.up_ready = '0;
        if (rst_n && accept) bus.up_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        down_valid_d = down_valid_q;
        down_data_d  = down_data_q;
        down_src_d   = down_src_q;
        ptr_d        = ptr_q;
        lock_d       = lock_q;
        own_d        = own_q;
        cnt_d        = cnt_q;
        if (accept) begin
            down_valid_d = 1'b1;
            down_data_d  = bus.up_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            down_src_d   = gnt_idx;
            if (owner_hold) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                own_d = gnt_idx;
                cnt_d = CNT_W'(1);
            end
            if (cnt_d == CNT_W'(BURST_LEN)) begin
                lock_d = 1'b0;
                ptr_d  = wrap_add(gnt_idx, 1);
            end else begin
                lock_d = 1'b1;
            end
        end else begin
            if (down_valid_q && bus.down_ready) down_valid_d = 1'b0;
            if (lock_q && !bus.up_valid[own_q]) begin
                lock_d = 1'b0;
                ptr_d  = wrap_add(own_q, 1);
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            down_valid_q <= 1'b0;
            down_data_q  <= '0;
            down_src_q   <= '0;
            ptr_q        <= '0;
            lock_q       <= 1'b0;
            own_q        <= '0;
            cnt_q        <= '0;
        end else begin
            down_valid_q <= down_valid_d;
            down_data_q  <= down_data_d;
            down_src_q   <= down_src_d;
            ptr_q        <= ptr_d;
            lock_q       <= lock_d;
            own_q        <= own_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.down_valid = down_valid_q;
    assign bus.down_data  = down_data_q;
    assign bus.down_src   = down_src_q;
endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Bench for vr_rr_arbiter: instance 0 has BURST_LEN=1, instance 1 BURST_LEN=4,
// both NUM_REQ=4; directed scenarios plus a randomized soak against a model.
module tb_vr_rr_arbiter;
    logic clk;
    logic rst_n;

    logic [1:0][3:0]       vld;
    logic [1:0][3:0][31:0] dat;
    logic [1:0]            rdy;
    logic [1:0][3:0]       urdy;
    logic [1:0]            dv;
    logic [1:0][31:0]      dd;
    logic [1:0][1:0]       ds;

    int n_checks = 0;
    int n_fail   = 0;
    int wcnt     = 0;

    int          m_ptr  [2];
    int          m_lock [2];
    int          m_own  [2];
    int          m_cnt  [2];
    int          m_dv   [2];
    int          m_ds   [2];
    logic [31:0] m_dd   [2];

    logic [31:0] q [4][$];

    vr_rr_arbiter_if #(.DATA_WIDTH(32), .NUM_REQ(4)) bus0 ();
    vr_rr_arbiter_if #(.DATA_WIDTH(32), .NUM_REQ(4)) bus1 ();

    vr_rr_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .BURST_LEN(1)) dut_bl1 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    vr_rr_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .BURST_LEN(4)) dut_bl4 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.up_valid   = vld[0];
    assign bus0.up_data    = dat[0];
    assign bus0.down_ready = rdy[0];
    assign bus1.up_valid   = vld[1];
    assign bus1.up_data    = dat[1];
    assign bus1.down_ready = rdy[1];
    assign urdy = {bus1.up_ready, bus0.up_ready};
    assign dv   = {bus1.down_valid, bus0.down_valid};
    assign dd   = {bus1.down_data, bus0.down_data};
    assign ds   = {bus1.down_src, bus0.down_src};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int bl(input int k);
        return (k == 1) ? 4 : 1;
    endfunction

    // Reference arbiter, stepped once per clock from the current inputs
    task automatic m_reset(input int k);
        m_ptr[k] = 0; m_lock[k] = 0; m_own[k] = 0; m_cnt[k] = 0;
        m_dv[k] = 0; m_ds[k] = 0; m_dd[k] = '0;
    endtask

    function automatic int m_grant(input int k);
        int start;
        if (m_lock[k] != 0 && vld[k][m_own[k]]) return m_own[k];
        start = (m_lock[k] != 0) ? (m_own[k] + 1) % 4 : m_ptr[k];
        for (int j = 0; j < 4; j++)
            if (vld[k][(start + j) % 4]) return (start + j) % 4;
        return -1;
    endfunction

    task automatic m_next(input int k);
        int g;
        bit can;
        g   = m_grant(k);
        can = (m_dv[k] == 0) || rdy[k];
        if (g >= 0 && can) begin
            if (m_lock[k] != 0 && g == m_own[k]) begin
                m_cnt[k]++;
            end else begin
                m_own[k] = g;
                m_cnt[k] = 1;
            end
            if (m_cnt[k] == bl(k)) begin
                m_lock[k] = 0;
                m_ptr[k]  = (g + 1) % 4;
            end else begin
                m_lock[k] = 1;
            end
            m_dv[k] = 1; m_dd[k] = dat[k][g]; m_ds[k] = g;
        end else begin
            if (m_dv[k] != 0 && rdy[k]) m_dv[k] = 0;
            if (m_lock[k] != 0 && !vld[k][m_own[k]]) begin
                m_lock[k] = 0;
                m_ptr[k]  = (m_own[k] + 1) % 4;
                m_cnt[k]  = 0;
            end
        end
    endtask

    task automatic do_reset();
        vld = '0; rdy = '0; dat = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset(0);
        m_reset(1);
    endtask

    task automatic test_reset();
        vld = '0; rdy = '0; dat = '0;
        @(negedge clk);
        rst_n = 1'b0;
        vld[0] = 4'hF; rdy[0] = 1'b1;
        for (int i = 0; i < 4; i++) dat[0][i] = 32'(i * 256);
        @(posedge clk); #1;
        n_checks++;
        if (urdy[0] !== 4'b0000) begin
            n_fail++; $display("FAIL reset_up_ready: got %b expected 0000", urdy[0]);
        end
        n_checks++;
        if (dv[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_down_valid: got %b expected 0", dv[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (dv[0] !== 1'b1 || ds[0] !== 2'd0) begin
            n_fail++; $display("FAIL reset_first_src: got valid=%b src=%0d expected valid=1 src=0", dv[0], ds[0]);
        end
    endtask

    task automatic test_fair_rotation();
        int seq [4];
        logic [3:0] acc;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            dat[0][i] = 32'(i * 256);
        end
        vld[0] = 4'hF; rdy[0] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            acc = vld[0] & urdy[0];
            @(posedge clk); #1;
            n_checks++;
            if (dv[0] !== 1'b1 || ds[0] !== 2'(c % 4)) begin
                n_fail++; $display("FAIL fair_src[%0d]: got valid=%b src=%0d expected src=%0d", c, dv[0], ds[0], c % 4);
            end
            n_checks++;
            if (dd[0] !== 32'((c % 4) * 256 + c / 4)) begin
                n_fail++; $display("FAIL fair_data[%0d]: got %h expected %h", c, dd[0], 32'((c % 4) * 256 + c / 4));
            end
            for (int i = 0; i < 4; i++)
                if (acc[i]) begin
                    seq[i]++;
                    dat[0][i] = 32'(i * 256 + seq[i]);
                end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        vld[0] = 4'b0100; dat[0][2] = 32'hA5A5_0001; rdy[0] = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (dv[0] !== 1'b1 || dd[0] !== 32'hA5A5_0001 || ds[0] !== 2'd2) begin
            n_fail++; $display("FAIL bp_first: got valid=%b data=%h src=%0d expected 1 a5a50001 2", dv[0], dd[0], ds[0]);
        end
        dat[0][2] = 32'hA5A5_0002;
        rdy[0] = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            n_checks++;
            if (urdy[0] !== 4'b0000) begin
                n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0000", s, urdy[0]);
            end
            n_checks++;
            if (dv[0] !== 1'b1 || dd[0] !== 32'hA5A5_0001) begin
                n_fail++; $display("FAIL bp_stall_data[%0d]: got valid=%b data=%h expected 1 a5a50001", s, dv[0], dd[0]);
            end
            @(posedge clk); #1;
        end
        rdy[0] = 1'b1;
        #1;
        n_checks++;
        if (urdy[0] !== 4'b0100) begin
            n_fail++; $display("FAIL bp_release_ready: got %b expected 0100", urdy[0]);
        end
        @(posedge clk); #1;
        n_checks++;
        if (dv[0] !== 1'b1 || dd[0] !== 32'hA5A5_0002) begin
            n_fail++; $display("FAIL bp_next_word: got valid=%b data=%h expected 1 a5a50002", dv[0], dd[0]);
        end
        vld[0] = 4'b0000;
        @(posedge clk); #1;
        n_checks++;
        if (dv[0] !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got valid=%b expected 0", dv[0]);
        end
    endtask

    task automatic test_burst_lock();
        int exp_src [12] = '{1, 1, 1, 1, 3, 3, 3, 3, 1, 1, 1, 1};
        int seq [4];
        int eseq [4];
        logic [3:0] acc;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0; eseq[i] = 0;
            dat[1][i] = 32'(i * 256);
        end
        vld[1] = 4'b1010; rdy[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            acc = vld[1] & urdy[1];
            @(posedge clk); #1;
            n_checks++;
            if (dv[1] !== 1'b1 || ds[1] !== 2'(exp_src[c])) begin
                n_fail++; $display("FAIL burst_src[%0d]: got valid=%b src=%0d expected %0d", c, dv[1], ds[1], exp_src[c]);
            end
            n_checks++;
            if (dd[1] !== 32'(exp_src[c] * 256 + eseq[exp_src[c]])) begin
                n_fail++; $display("FAIL burst_data[%0d]: got %h expected %h", c, dd[1], 32'(exp_src[c] * 256 + eseq[exp_src[c]]));
            end
            eseq[exp_src[c]]++;
            for (int i = 0; i < 4; i++)
                if (acc[i]) begin
                    seq[i]++;
                    dat[1][i] = 32'(i * 256 + seq[i]);
                end
            @(negedge clk);
        end
    endtask

    task automatic test_early_release();
        int exp_src [6] = '{1, 1, 3, 3, 3, 3};
        int seq [4];
        logic [3:0] acc;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            dat[1][i] = 32'(i * 256);
        end
        vld[1] = 4'b1010; rdy[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            acc = vld[1] & urdy[1];
            if (c == 2) begin
                n_checks++;
                if (urdy[1] !== 4'b1000) begin
                    n_fail++; $display("FAIL early_grant: got %b expected 1000", urdy[1]);
                end
            end
            @(posedge clk); #1;
            n_checks++;
            if (dv[1] !== 1'b1 || ds[1] !== 2'(exp_src[c])) begin
                n_fail++; $display("FAIL early_src[%0d]: got valid=%b src=%0d expected %0d", c, dv[1], ds[1], exp_src[c]);
            end
            for (int i = 0; i < 4; i++)
                if (acc[i]) begin
                    seq[i]++;
                    dat[1][i] = 32'(i * 256 + seq[i]);
                end
            if (c == 1) vld[1][1] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_random_soak(input int k, input int n);
        int          waited [4];
        int          g;
        logic [3:0]  exp_rdy;
        logic [3:0]  acc;
        logic [31:0] w;
        logic [31:0] exp_w;
        bit          prev_stall;
        logic [31:0] prev_dd;
        logic [1:0]  prev_ds;
        int          left;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            waited[i] = 0;
            q[i].delete();
        end
        prev_stall = 1'b0; prev_dd = '0; prev_ds = '0;
        for (int cyc = 0; cyc < n + 100; cyc++) begin
            if (cyc < n) begin
                for (int i = 0; i < 4; i++)
                    if (!vld[k][i] && $urandom_range(0, 99) < 35) begin
                        w = {4'(k), 4'(i), 24'(wcnt)};
                        wcnt++;
                        dat[k][i] = w;
                        vld[k][i] = 1'b1;
                        q[i].push_back(w);
                    end
                rdy[k] = ($urandom_range(0, 99) < 65);
            end else begin
                rdy[k] = 1'b1;
            end
            #1;
            n_checks++;
            if (dv[k] !== (m_dv[k] != 0) || (m_dv[k] != 0 && (dd[k] !== m_dd[k] || ds[k] !== 2'(m_ds[k])))) begin
                n_fail++; $display("FAIL soak%0d_down[%0d]: got v=%b d=%h s=%0d expected v=%0d d=%h s=%0d",
                                   k, cyc, dv[k], dd[k], ds[k], m_dv[k], m_dd[k], m_ds[k]);
            end
            if (prev_stall) begin
                n_checks++;
                if (dv[k] !== 1'b1 || dd[k] !== prev_dd || ds[k] !== prev_ds) begin
                    n_fail++; $display("FAIL soak%0d_stall[%0d]: got v=%b d=%h s=%0d expected 1 %h %0d",
                                       k, cyc, dv[k], dd[k], ds[k], prev_dd, prev_ds);
                end
            end
            g = m_grant(k);
            exp_rdy = '0;
            if (g >= 0 && (m_dv[k] == 0 || rdy[k])) exp_rdy[g] = 1'b1;
            n_checks++;
            if (urdy[k] !== exp_rdy) begin
                n_fail++; $display("FAIL soak%0d_ready[%0d]: got %b expected %b", k, cyc, urdy[k], exp_rdy);
            end
            if (dv[k] && rdy[k]) begin
                n_checks++;
                if (q[ds[k]].size() == 0) begin
                    n_fail++; $display("FAIL soak%0d_dup[%0d]: got word %h from src %0d expected none pending", k, cyc, dd[k], ds[k]);
                end else begin
                    exp_w = q[ds[k]].pop_front();
                    if (dd[k] !== exp_w) begin
                        n_fail++; $display("FAIL soak%0d_order[%0d]: got %h expected %h", k, cyc, dd[k], exp_w);
                    end
                end
            end
            acc = vld[k] & urdy[k];
            for (int i = 0; i < 4; i++) begin
                if (acc[i] || !vld[k][i]) begin
                    waited[i] = 0;
                end else if (acc != 4'b0000) begin
                    waited[i]++;
                    n_checks++;
                    if (waited[i] > 4 * bl(k)) begin
                        n_fail++; $display("FAIL soak%0d_starve[%0d]: src %0d waited %0d accepts, limit %0d", k, cyc, i, waited[i], 4 * bl(k));
                    end
                end
            end
            prev_stall = dv[k] && !rdy[k];
            prev_dd    = dd[k];
            prev_ds    = ds[k];
            m_next(k);
            @(posedge clk); #1;
            vld[k] = vld[k] & ~acc;
            @(negedge clk);
        end
        left = 0;
        for (int i = 0; i < 4; i++) left += q[i].size();
        n_checks++;
        if (left != 0 || vld[k] !== 4'b0000 || dv[k] !== 1'b0) begin
            n_fail++; $display("FAIL soak%0d_drain: got %0d words pending, valid=%b out=%b expected 0 0000 0", k, left, vld[k], dv[k]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vld = '0; rdy = '0; dat = '0;
        m_reset(0);
        m_reset(1);
        test_reset();
        test_fair_rotation();
        test_backpressure();
        test_burst_lock();
        test_early_release();
        test_random_soak(1, 2000);
        test_random_soak(0, 1000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
